// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Shares one FIFO write port among NUM_REQ requesters using a
//               round-robin arbiter with burst ownership. An owner keeps the
//               port for up to BURST_LEN consecutive accepted words. After
//               that, the arbiter searches again, starting at the index after
//               the owner. The grant is zero-latency: a word shown together
//               with its grant is written on the same rising edge.
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous active-low reset
//               req          - per-requester write request
//               req_data     - packed request data, slice i = requester i
//               gnt          - one-hot grant (combinational)
//               fifo_wr_en   - FIFO write enable
//               fifo_din     - FIFO write data
//               fifo_full    - FIFO full flag
//               burst_active - an owner holds an unfinished burst
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic                          burst_active
);

    localparam int c_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [c_ID_W-1:0]  c_LAST_RST  = c_ID_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_BURST_MAX = c_CNT_W'(BURST_LEN);

    logic                r_owner_valid_q, w_owner_valid_d;
    logic [c_ID_W-1:0]   r_owner_id_q,    w_owner_id_d;
    logic [c_ID_W-1:0]   r_last_id_q,     w_last_id_d;
    logic [c_CNT_W-1:0]  r_burst_cnt_q,   w_burst_cnt_d;

    logic                w_cont;
    logic                w_arb_found;
    logic [c_ID_W-1:0]   w_arb_idx;
    logic [c_ID_W-1:0]   w_sel_idx;
    logic                w_take;
    logic                w_grant;

    // The owner may continue while it still requests and has burst budget left.
    assign w_cont = r_owner_valid_q && req[r_owner_id_q] && (r_burst_cnt_q < c_BURST_MAX);

    // Round-robin search starting one past the last winner. The last winner is
    // checked last, so a finished owner gets the port back only when nobody
    // else is asking.
    always_comb begin
        int idx;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_last_id_q) + 1 + k) % NUM_REQ;
            if (!w_arb_found && req[idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = c_ID_W'(idx);
            end
        end
    end

    assign w_sel_idx = w_cont ? r_owner_id_q : w_arb_idx;
    assign w_take    = !fifo_full && (w_cont || w_arb_found);
    // Outputs are masked while reset is held, not only after the next edge.
    assign w_grant   = rst_n && w_take;

    always_comb begin
        gnt      = '0;
        fifo_din = '0;
        if (w_grant) begin
            gnt[w_sel_idx] = 1'b1;
            fifo_din       = req_data[int'(w_sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign fifo_wr_en   = |gnt;
    assign burst_active = rst_n && r_owner_valid_q;

    // A full FIFO freezes all state, so a stalled burst resumes where it stopped.
    always_comb begin
        w_owner_valid_d = r_owner_valid_q;
        w_owner_id_d    = r_owner_id_q;
        w_last_id_d     = r_last_id_q;
        w_burst_cnt_d   = r_burst_cnt_q;
        if (w_take) begin
            if (w_cont) begin
                w_burst_cnt_d = r_burst_cnt_q + c_CNT_W'(1);
            end else begin
                w_owner_valid_d = 1'b1;
                w_owner_id_d    = w_arb_idx;
                w_last_id_d     = w_arb_idx;
                w_burst_cnt_d   = c_CNT_W'(1);
            end
        end else if (!fifo_full) begin
            // No grant for any requester: the burst is over. last_id is
            // kept so fairness carries across idle gaps.
            w_owner_valid_d = 1'b0;
            w_burst_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_valid_q <= 1'b0;
            r_owner_id_q    <= '0;
            r_last_id_q     <= c_LAST_RST;
            r_burst_cnt_q   <= '0;
        end else begin
            r_owner_valid_q <= w_owner_valid_d;
            r_owner_id_q    <= w_owner_id_d;
            r_last_id_q     <= w_last_id_d;
            r_burst_cnt_q   <= w_burst_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Scoreboard testbench for fifo_wr_arbiter (8-bit data,
//               4 requesters, burst of 4). Each requester sends the data
//               {id*64 + word index} and moves to its next word when granted.
//               The sink is a 16-deep FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic        burst_active;

    logic        force_full;
    logic        drain;
    int          fifo_cnt = 0;
    logic [7:0]  fifo_q [$];
    logic [7:0]  seq [4] = '{default: 8'h00};
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .BURST_LEN  (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .fifo_full    (fifo_full),
        .burst_active (burst_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_full = force_full || (fifo_cnt >= 16);

    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = 8'(i * 64) + seq[i];
        end
    end

    // Requesters advance their word on the edge where they are granted.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) seq[i] <= seq[i] + 8'd1;
        end
    end

    // Sink FIFO model.
    always @(posedge clk) begin
        if (drain && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (fifo_wr_en) fifo_q.push_back(fifo_din);
        fifo_cnt <= fifo_q.size();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got gnt=0x%0h din=0x%0h, expected no write (t=%0t)",
                         gnt, fifo_din, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_gnt", 32'(gnt), 32'(e.g));
                check("sb_din", 32'(fifo_din), 32'(e.d));
                check("sb_not_full", 32'(fifo_full), 32'd0);
            end
        end else begin
            check("idle_gnt", 32'(gnt), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_burst(input int r, input int first, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.g = 4'(1 << r);
            e.d = 8'(r * 64 + first + j);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_exp_empty(input int budget, input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        #2;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        rst_n      = 1'b0;
        req        = 4'b0000;
        force_full = 1'b0;
        drain      = 1'b0;
        tick();
        tick();
        check("rst_gnt",   32'(gnt),          32'd0);
        check("rst_wr_en", 32'(fifo_wr_en),   32'd0);
        check("rst_ba",    32'(burst_active), 32'd0);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (5) begin
            @(negedge clk);
            check("idle_wr_en", 32'(fifo_wr_en),   32'd0);
            check("idle_ba",    32'(burst_active), 32'd0);
        end

        // All four requesting: one burst of 4 each, starting at requester 0, until the FIFO fills.
        tick();
        push_burst(0, 0, 4);
        push_burst(1, 0, 4);
        push_burst(2, 0, 4);
        push_burst(3, 0, 4);
        req = 4'b1111;
        wait_exp_empty(40, "all_done");
        check("all_fifo_full", 32'(fifo_full), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("full_wr_en", 32'(fifo_wr_en),   32'd0);
            check("full_ba",    32'(burst_active), 32'd1);
        end
        for (int k = 0; k < 16; k++) begin
            check("all_readback", 32'(fifo_q[k]), 32'((k / 4) * 64 + (k % 4)));
        end
        tick();
        req   = 4'b0000;
        drain = 1'b1;
        c = 0;
        while (fifo_cnt != 0 && c < 40) begin
            tick();
            c++;
        end
        check("drain_empty", 32'(fifo_cnt), 32'd0);
        tick();

        // Requesters 0 and 1 alternate bursts with no idle cycle.
        push_burst(0, 4, 4);
        push_burst(1, 4, 4);
        push_burst(0, 8, 4);
        push_burst(1, 8, 4);
        req = 4'b0011;
        repeat (16) begin
            @(negedge clk);
            check("alt_wr_en", 32'(fifo_wr_en), 32'd1);
        end
        tick();
        req = 4'b0000;
        wait_exp_empty(4, "alt_done");
        tick();
        check("alt_ba_clear", 32'(burst_active), 32'd0);

        // Single requester 2: back-to-back bursts with no gap.
        push_burst(2, 4, 10);
        req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("solo_gnt", 32'(gnt), 32'h4);
            if (k > 0) check("solo_ba", 32'(burst_active), 32'd1);
        end
        tick();
        req = 4'b0000;
        wait_exp_empty(4, "solo_done");
        tick();

        // Stall mid-burst: 2 words, 3 full cycles, 2 more words, then requester 1.
        push_burst(0, 12, 4);
        push_burst(1, 12, 4);
        req = 4'b0011;
        tick();
        tick();
        force_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_gnt",   32'(gnt),          32'd0);
            check("stall_wr_en", 32'(fifo_wr_en),   32'd0);
            check("stall_ba",    32'(burst_active), 32'd1);
        end
        tick();
        force_full = 1'b0;
        repeat (6) tick();
        req = 4'b0000;
        wait_exp_empty(4, "stall_done");
        tick();

        // Reset in the middle of requester 2's burst.
        push_burst(2, 14, 2);
        push_burst(1, 16, 1);
        req = 4'b0110;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_gnt",   32'(gnt),          32'd0);
        check("midrst_wr_en", 32'(fifo_wr_en),   32'd0);
        check("midrst_din",   32'(fifo_din),     32'd0);
        check("midrst_ba",    32'(burst_active), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req = 4'b0000;
        wait_exp_empty(4, "midrst_done");

        // After reset the search restarts at index 0, so requester 1 wins over requester 3.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        push_burst(1, 17, 1);
        req = 4'b1010;
        tick();
        req = 4'b0000;
        wait_exp_empty(4, "rst_search_done");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each requester's data word and of the FIFO write data.
REQ-002 Parameter NUM_REQ, default 4, number of requesters sharing the FIFO write port (legal range 2..8).
REQ-003 Parameter BURST_LEN, default 4, maximum consecutive accepted words per grant ownership (legal range 1..16).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port req  input  NUM_REQ  per-requester write request; bit i high means req_data slice i is valid.
REQ-007 Port req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port gnt  output  NUM_REQ  one-hot grant; gnt[i] high means requester i's word is written at this rising edge.
REQ-009 Port fifo_wr_en  output  1  FIFO write enable.
REQ-010 Port fifo_din  output  DATA_WIDTH  FIFO write data.
REQ-011 Port fifo_full  input  1  FIFO full flag.
REQ-012 Port burst_active  output  1  high while an owner holds an unfinished burst (owner_valid).

Function
REQ-013 State: owner_valid (1b), owner_id, last_id (clog2(NUM_REQ) bits each), burst_cnt (clog2(BURST_LEN+1) bits).
REQ-014 gnt is combinational from state, req and fifo_full; at most one bit high; all zero when fifo_full=1 or req=0.
REQ-015 fifo_wr_en = OR of gnt; fifo_din = req_data slice of the granted index, all zeros when no grant.
REQ-016 Continuation: if owner_valid, req[owner_id]=1 and burst_cnt<BURST_LEN, grant owner_id.
REQ-017 Otherwise arbitrate: grant the first index with req=1, searching from (last_id+1) mod NUM_REQ upward with wrap-around.
REQ-018 Accepted word on continuation: burst_cnt increments by 1; owner unchanged.
REQ-019 Accepted word on new arbitration: owner_id=last_id=granted index, owner_valid=1, burst_cnt=1.
REQ-020 Burst exhausted (burst_cnt=BURST_LEN): next cycle arbitrates; former owner is re-granted only if no other requester is active, starting a new burst with burst_cnt=1 and no idle cycle.
REQ-021 Owner drops req: burst ends that cycle; arbitration per REQ-017 in the same cycle; owner_valid clears if no grant issues.
REQ-022 fifo_full=1: no grant, all state held (owner, last_id, burst_cnt); burst resumes where it stopped when full clears.
REQ-023 req=0 with fifo_full=0: owner_valid clears, burst_cnt=0, last_id retained.
REQ-024 Zero-latency: word presented with grant is written the same rising edge; requester advances its data on that edge.
REQ-025 Requests not granted are held by the requester; the block never drops or duplicates a word.

Reset
REQ-026 rst_n=0 asynchronously forces owner_valid=0, burst_cnt=0, last_id=NUM_REQ-1, and forces gnt=0, fifo_wr_en=0, fifo_din=0, burst_active=0 while asserted.
REQ-027 First arbitration after reset release searches from index 0.
REQ-028 Reset asserted mid-burst discards the burst; no partial state survives.

Verification (DATA_WIDTH=8, NUM_REQ=4, BURST_LEN=4; real fifo, DEPTH=16, as sink; scoreboard per-requester queues)
REQ-029 Reset, req=4'b0000 for 5 cycles -> gnt=0, fifo_wr_en=0, burst_active=0 every cycle.
REQ-030 req=4'b1111 held, distinct data per requester -> gnt 0001 x4, 0010 x4, 0100 x4, 1000 x4; FIFO reads back 16 words in that order; fifo_full=1 afterwards.
REQ-031 req=4'b0011 held, FIFO drained continuously -> gnt alternates 0001 x4, 0010 x4 with no idle cycles.
REQ-032 req=4'b0100 only -> gnt=0100 every cycle, burst_cnt cycles 1,2,3,4,1,... with no gap.
REQ-033 req=4'b0011, fifo_full forced 1 after 2 words of requester 0 for 3 cycles -> gnt=0, fifo_wr_en=0 for 3 cycles; then requester 0 gets 2 more words, then requester 1.
REQ-034 rst_n pulsed low mid-burst of requester 2 with req=4'b0110 -> outputs zero immediately; after release first grant goes to requester 1.
